// File: rtl/hd_load_sequencer_pkg.sv
// hd_ctrl_pkg: shared types and default beat counts
// for the HD inference load sequencer.
package hd_ctrl_pkg;

  localparam int BEAT_CNT_W = 17;

  localparam int PROJ_BEATS_DEF  = 125;
  localparam int FEAT_BEATS_DEF  = 514;
  localparam int CLASS_BEATS_DEF = 104000;
  localparam int COEFF_BEATS_DEF = 26;
  localparam int RUN_TMO_DEF     = 65535;
  localparam int RST_CYCLES_DEF  = 2;

  typedef logic [BEAT_CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARST,
    S_LD_PROJ,
    S_LD_FEAT,
    S_LD_CLASS,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/hd_load_sequencer_if.sv
// Host-side bus of the load sequencer:
// beat stream in, held result out.
interface hd_load_sequencer_if;
  logic        host_valid;
  logic        host_ready;
  logic [31:0] host_data;
  logic [15:0] result_val;
  logic [15:0] result_idx;
  logic        result_valid;
  logic        result_ack;

  modport master (
    output host_valid, host_data, result_ack,
    input  host_ready, result_val, result_idx,
           result_valid
  );

  modport slave (
    input  host_valid, host_data, result_ack,
    output host_ready, result_val, result_idx,
           result_valid
  );
endinterface

// File: rtl/hd_beat_counter.sv
// Clearable up-counter with terminal compare;
// shared by beat, timeout and reset-pulse counting.
module hd_beat_counter
  import hd_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  cnt_t term,
  output cnt_t cnt,
  output logic at_term
);

  // clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + cnt_t'(1);
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/hd_load_sequencer.sv
// Sequences one HD inference: accel reset, three
// memory loads, run with timeout, result hold.
module hd_load_sequencer
  import hd_ctrl_pkg::*;
#(
  parameter int PROJ_BEATS  = PROJ_BEATS_DEF,
  parameter int FEAT_BEATS  = FEAT_BEATS_DEF,
  parameter int CLASS_BEATS = CLASS_BEATS_DEF,
  parameter int COEFF_BEATS = COEFF_BEATS_DEF,
  parameter int RUN_TIMEOUT = RUN_TMO_DEF,
  parameter int RST_CYCLES  = RST_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  hd_load_sequencer_if.slave host,
  output logic [1:0][15:0] projections_in,
  output logic [31:0]      feature_in,
  output logic [7:0]       class_in,
  output logic [15:0]      coeffs_in,
  output logic             projection_write,
  output logic             feature_write,
  output logic             class_write,
  output logic             accel_reset,
  input  logic             all_done,
  input  logic [15:0]      max_val,
  input  logic [15:0]      max_index,
  output logic             busy,
  output logic             error
);

  state_t state, nxt;
  cnt_t   cnt, term;
  logic   at_term, inc, clr, acc;
  logic   proj_acc, feat_acc, cls_acc;
  logic   tmo_hit, run_ok;
  logic [15:0] r_val, r_idx;
  logic        r_valid;

  hd_beat_counter u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .inc     (inc),
    .term    (term),
    .cnt     (cnt),
    .at_term (at_term)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  // next state, counter control, accept
  always_comb begin
    nxt  = state;
    inc  = 1'b0;
    term = '0;
    acc  = 1'b0;
    unique case (state)
      S_IDLE: if (start) nxt = S_ARST;
      S_ARST: begin
        inc  = 1'b1;
        term = cnt_t'(RST_CYCLES - 1);
        if (at_term) nxt = S_LD_PROJ;
      end
      S_LD_PROJ: begin
        term = cnt_t'(PROJ_BEATS - 1);
        acc  = host.host_valid;
        inc  = acc;
        if (acc && at_term) nxt = S_LD_FEAT;
      end
      S_LD_FEAT: begin
        term = cnt_t'(FEAT_BEATS - 1);
        acc  = host.host_valid;
        inc  = acc;
        if (acc && at_term) nxt = S_LD_CLASS;
      end
      S_LD_CLASS: begin
        term = cnt_t'(CLASS_BEATS - 1);
        acc  = host.host_valid;
        inc  = acc;
        if (acc && at_term) nxt = S_RUN;
      end
      S_RUN: begin
        inc  = 1'b1;
        term = cnt_t'(RUN_TIMEOUT);
        if (all_done)     nxt = S_DONE;
        else if (at_term) nxt = S_IDLE;
      end
      S_DONE: if (host.result_ack) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort) begin
      nxt = S_IDLE;
      acc = 1'b0;
      inc = 1'b0;
    end
  end

  assign clr      = (nxt != state);
  assign proj_acc = acc && (state == S_LD_PROJ);
  assign feat_acc = acc && (state == S_LD_FEAT);
  assign cls_acc  = acc && (state == S_LD_CLASS);
  assign run_ok   = (state == S_RUN) && all_done
                    && !abort;
  assign tmo_hit  = (state == S_RUN) && !all_done
                    && at_term && !abort;

  // registered payload, strobes, result, error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      projections_in   <= '0;
      feature_in       <= '0;
      class_in         <= '0;
      coeffs_in        <= '0;
      projection_write <= 1'b0;
      feature_write    <= 1'b0;
      class_write      <= 1'b0;
      r_val            <= '0;
      r_idx            <= '0;
      r_valid          <= 1'b0;
      error            <= 1'b0;
    end else begin
      projection_write <= proj_acc;
      feature_write    <= feat_acc;
      class_write      <= cls_acc;
      if (proj_acc) projections_in <= host.host_data;
      if (feat_acc) feature_in <= host.host_data;
      if (cls_acc) begin
        class_in <= host.host_data[7:0];
        if (cnt < cnt_t'(COEFF_BEATS))
          coeffs_in <= host.host_data[31:16];
      end
      if (state == S_IDLE && start && !abort)
        error <= 1'b0;
      else if (tmo_hit)
        error <= 1'b1;
      if (abort) begin
        r_valid <= 1'b0;
      end else if (run_ok) begin
        r_val   <= max_val;
        r_idx   <= max_index;
        r_valid <= 1'b1;
      end else if (state == S_DONE && host.result_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign host.host_ready   = (state == S_LD_PROJ)
                          || (state == S_LD_FEAT)
                          || (state == S_LD_CLASS);
  assign host.result_val   = r_val;
  assign host.result_idx   = r_idx;
  assign host.result_valid = r_valid;
  assign accel_reset = (state == S_IDLE)
                    || (state == S_ARST);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_hd_load_sequencer.sv
// Directed bench for hd_load_sequencer with
// small beat counts and a strobe logger.
module tb_hd_load_sequencer;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, abort;
  logic [1:0][15:0] projections_in;
  logic [31:0]      feature_in;
  logic [7:0]       class_in;
  logic [15:0]      coeffs_in;
  logic             projection_write;
  logic             feature_write;
  logic             class_write;
  logic             accel_reset;
  logic             all_done;
  logic [15:0]      max_val, max_index;
  logic             busy, error;

  int n_tests = 0;
  int n_fail  = 0;
  int multi_err = 0;

  logic [31:0] proj_log[$];
  logic [31:0] feat_log[$];
  logic [31:0] class_log[$];
  logic [31:0] coeff_log[$];

  hd_load_sequencer_if hif();

  hd_load_sequencer #(
    .PROJ_BEATS  (4),
    .FEAT_BEATS  (3),
    .CLASS_BEATS (5),
    .COEFF_BEATS (2),
    .RUN_TIMEOUT (20),
    .RST_CYCLES  (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .host             (hif),
    .projections_in   (projections_in),
    .feature_in       (feature_in),
    .class_in         (class_in),
    .coeffs_in        (coeffs_in),
    .projection_write (projection_write),
    .feature_write    (feature_write),
    .class_write      (class_write),
    .accel_reset      (accel_reset),
    .all_done         (all_done),
    .max_val          (max_val),
    .max_index        (max_index),
    .busy             (busy),
    .error            (error)
  );

  always #5 clk = ~clk;

  // log every strobe and flag overlapping ones
  always @(negedge clk) begin
    if (projection_write) proj_log.push_back(projections_in);
    if (feature_write)    feat_log.push_back(feature_in);
    if (class_write) begin
      class_log.push_back({24'h0, class_in});
      coeff_log.push_back({16'h0, coeffs_in});
    end
    if (32'(projection_write) + 32'(feature_write)
        + 32'(class_write) > 1)
      multi_err++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    proj_log.delete();
    feat_log.delete();
    class_log.delete();
    coeff_log.delete();
  endtask

  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d);
    int guard = 0;
    hif.host_valid = 1'b1;
    hif.host_data  = d;
    while (!hif.host_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("ready_wait", 0, 1);
    tick();
    hif.host_valid = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    all_done = 1'b0;
    max_val = '0;
    max_index = '0;
    hif.host_valid = 1'b0;
    hif.host_data  = '0;
    hif.result_ack = 1'b0;
    repeat (2) tick();
    check("rst_accel_reset", 32'(accel_reset), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(hif.host_ready), 0);
    check("rst_rvalid", 32'(hif.result_valid), 0);
    check("rst_error", 32'(error), 0);
    check("rst_wr", 32'({projection_write,
          feature_write, class_write}), 0);
    reset = 1'b1;
    tick();

    // 1: back-to-back load, data = {i,i}
    clear_logs();
    start_job();
    check("arst_accel_reset", 32'(accel_reset), 1);
    for (int i = 0; i < 12; i++)
      send_beat({16'(i), 16'(i)});
    check("t1_ready_run", 32'(hif.host_ready), 0);
    tick();
    check("t1_proj_n", proj_log.size(), 4);
    check("t1_feat_n", feat_log.size(), 3);
    check("t1_class_n", class_log.size(), 5);
    if (proj_log.size() == 4 && feat_log.size() == 3
        && class_log.size() == 5) begin
      check("t1_proj0", proj_log[0], 32'h0000_0000);
      check("t1_proj3", proj_log[3], 32'h0003_0003);
      check("t1_feat0", feat_log[0], 32'h0004_0004);
      check("t1_feat2", feat_log[2], 32'h0006_0006);
      check("t1_class0", class_log[0], 7);
      check("t1_class4", class_log[4], 11);
      check("t1_coeff0", coeff_log[0], 7);
      check("t1_coeff1", coeff_log[1], 8);
      check("t1_coeff4", coeff_log[4], 8);
    end

    // 3: all_done during RUN
    repeat (3) tick();
    all_done  = 1'b1;
    max_val   = 16'h00AB;
    max_index = 16'd7;
    tick();
    all_done  = 1'b0;
    max_val   = 16'h1234;
    check("t3_rvalid", 32'(hif.result_valid), 1);
    check("t3_rval", 32'(hif.result_val), 32'h00AB);
    check("t3_ridx", 32'(hif.result_idx), 7);
    repeat (3) tick();
    check("t3_hold", 32'(hif.result_valid), 1);
    check("t3_busy", 32'(busy), 1);
    hif.result_ack = 1'b1;
    tick();
    hif.result_ack = 1'b0;
    check("t3_rvalid_ack", 32'(hif.result_valid), 0);
    check("t3_idle", 32'(busy), 0);
    check("t3_error", 32'(error), 0);

    // 2: gapped load, data = 100+i
    clear_logs();
    start_job();
    for (int i = 0; i < 12; i++) begin
      send_beat(32'(100 + i));
      tick();
    end
    check("t2_proj_n", proj_log.size(), 4);
    check("t2_feat_n", feat_log.size(), 3);
    check("t2_class_n", class_log.size(), 5);
    if (proj_log.size() == 4 && class_log.size() == 5) begin
      check("t2_proj1", proj_log[1], 101);
      check("t2_class4", class_log[4], 111);
    end

    // 4: timeout; RUN began 1 cycle before loop
    k = 1;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    check("t4_cycles", k, 21);
    check("t4_error", 32'(error), 1);
    check("t4_accel_reset", 32'(accel_reset), 1);
    check("t4_rvalid", 32'(hif.result_valid), 0);
    start_job();
    check("t4_err_clr", 32'(error), 0);

    // 5: abort on third feature beat
    clear_logs();
    for (int i = 0; i < 6; i++)
      send_beat(32'(200 + i));
    hif.host_valid = 1'b1;
    hif.host_data  = 32'd206;
    abort = 1'b1;
    check("t5_ready_pre", 32'(hif.host_ready), 1);
    tick();
    abort = 1'b0;
    hif.host_valid = 1'b0;
    check("t5_busy", 32'(busy), 0);
    check("t5_ready", 32'(hif.host_ready), 0);
    check("t5_fwr", 32'(feature_write), 0);
    repeat (4) tick();
    check("t5_feat_n", feat_log.size(), 2);
    check("t5_error", 32'(error), 0);
    clear_logs();
    start_job();
    send_beat(32'h0000_0055);
    check("t5_re_pwr", 32'(projection_write), 1);
    check("t5_re_proj", projections_in, 32'h55);

    // 6: async reset mid LD_CLASS
    for (int i = 1; i < 9; i++)
      send_beat(32'h0009_0000 + 32'(i));
    check("t6_in_class", 32'(class_write), 1);
    reset = 1'b0;
    #1;
    check("t6_cwr", 32'(class_write), 0);
    check("t6_class", 32'(class_in), 0);
    check("t6_coeff", 32'(coeffs_in), 0);
    check("t6_accel_reset", 32'(accel_reset), 1);
    check("t6_busy", 32'(busy), 0);
    check("t6_ready", 32'(hif.host_ready), 0);
    tick();
    reset = 1'b1;
    tick();

    check("strobe_excl", multi_err, 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
